// File: rtl/timer_rr_sched.sv
// Round-robin arbiter that lends a single prescaled down-counter timer to N_REQ
// requesters, latching the winner's configuration and returning a done pulse.
module timer_rr_sched #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDW   = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req,
   input  logic [5*N_REQ-1:0]    psc_in,
   input  logic [16*N_REQ-1:0]   reload_in,
   output logic [N_REQ-1:0]      gnt,
   output logic [N_REQ-1:0]      done,
   output logic                  busy,
   output logic [IDW-1:0]        cur_id,
   output logic [4:0]            tmr_psc,
   output logic [15:0]           tmr_reload,
   output logic                  tmr_load,
   output logic                  tmr_en,
   input  logic                  tmr_done
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t           state;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   nxt_id;
   logic             pick_vld;
   logic [IDW-1:0]   pick_id;
   logic [4:0]       pick_psc;
   logic [15:0]      pick_reload;
   logic [IDW:0]     scan;

   // First pending request at or above rr_ptr, wrapping; scanned from the far
   // end so the nearest candidate is the last one written.
   always_comb begin
      pick_vld    = 1'b0;
      pick_id     = '0;
      scan        = '0;
      pick_psc    = '0;
      pick_reload = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         scan = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (scan >= (IDW+1)'(N_REQ)) begin
            scan = scan - (IDW+1)'(N_REQ);
         end
         if (req[scan[IDW-1:0]]) begin
            pick_vld = 1'b1;
            pick_id  = scan[IDW-1:0];
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_id == IDW'(i)) begin
            pick_psc    = psc_in[5*i +: 5];
            pick_reload = reload_in[16*i +: 16];
         end
      end
   end

   assign nxt_id = (cur_id == IDW'(N_REQ - 1)) ? '0 : cur_id + IDW'(1);

   // Moore FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         cur_id     <= '0;
         gnt        <= '0;
         done       <= '0;
         busy       <= 1'b0;
         tmr_load   <= 1'b0;
         tmr_en     <= 1'b0;
         tmr_psc    <= '0;
         tmr_reload <= '0;
      end else begin
         done     <= '0;
         tmr_load <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  state      <= LOAD;
                  cur_id     <= pick_id;
                  tmr_psc    <= pick_psc;
                  tmr_reload <= pick_reload;
                  gnt        <= N_REQ'(1) << pick_id;
                  busy       <= 1'b1;
                  tmr_load   <= 1'b1;
               end
            end
            LOAD: begin
               if (tmr_reload == 16'd0) begin
                  state <= DONE;
                  done  <= gnt;
               end else begin
                  state  <= RUN;
                  tmr_en <= 1'b1;
               end
            end
            RUN: begin
               // Completion outranks an abort arriving on the same edge.
               if (tmr_done) begin
                  state  <= DONE;
                  tmr_en <= 1'b0;
                  done   <= gnt;
               end else if (!req[cur_id]) begin
                  state  <= IDLE;
                  tmr_en <= 1'b0;
                  gnt    <= '0;
                  busy   <= 1'b0;
                  rr_ptr <= nxt_id;
               end
            end
            DONE: begin
               state  <= IDLE;
               gnt    <= '0;
               busy   <= 1'b0;
               tmr_en <= 1'b0;
               rr_ptr <= nxt_id;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/timer_rr_sched.md
# timer_rr_sched

Round-robin scheduler that shares one prescaled 16-bit down-counter timer (5-bit prescaler, 16-bit reload, single-cycle completion flag) among N_REQ requesters. Each requester raises a request with its own prescaler and reload values. The scheduler grants the timer to one requester at a time, loads that requester's configuration, runs the timer, and returns a one-cycle done pulse to the owner. It sits between the lab's requesting FSMs and the single timer instance.

## Interface
- N_REQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(N_REQ), width of cur_id.

- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low.
- req  in  N_REQ  per-requester request level; held high until done or abort.
- psc_in  in  5*N_REQ  requester i prescaler at [5*i+4:5*i].
- reload_in  in  16*N_REQ  requester i reload at [16*i+15:16*i].
- gnt  out  N_REQ  one-hot owner; all zero when idle.
- done  out  N_REQ  one-cycle completion pulse to the owner.
- busy  out  1  high whenever state is not IDLE.
- cur_id  out  IDW  index of the current or last owner.
- tmr_psc  out  5  latched prescaler driven to the timer.
- tmr_reload  out  16  latched reload driven to the timer.
- tmr_load  out  1  one-cycle load strobe to the timer.
- tmr_en  out  1  timer count enable.
- tmr_done  in  1  timer expiry pulse; the counter has reached 0.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from registered state only (Moore).
- Reset, when reset=0 at an edge, sets:
  - state=IDLE, rr_ptr=0, cur_id=0
  - gnt=0, done=0, busy=0, tmr_load=0, tmr_en=0
  - tmr_psc=0, tmr_reload=0
- IDLE:
  - If any req bit is high, select the first high bit scanning from rr_ptr upward, wrapping modulo N_REQ.
  - Register cur_id, tmr_psc and tmr_reload from the winner's slices, then go to LOAD.
  - If no req bit is high, stay in IDLE.
- LOAD:
  - tmr_load=1 and tmr_en=0.
  - If tmr_reload==0, go to DONE (zero-length request, the timer is never enabled). Otherwise go to RUN.
- RUN:
  - tmr_en=1.
  - If tmr_done=1, go to DONE.
  - Else if req[cur_id]=0 (abort), go to IDLE and set rr_ptr=cur_id+1 mod N_REQ. No done pulse is issued.
  - If tmr_done and the req drop occur on the same edge, completion wins and the FSM goes to DONE.
- DONE:
  - done[cur_id]=1 for exactly this cycle, tmr_en=0.
  - Next edge: set rr_ptr=cur_id+1 mod N_REQ and go to IDLE.
- gnt = one-hot(cur_id) in LOAD, RUN and DONE; gnt=0 in IDLE.
- done is never asserted to a non-owner, and never more than one bit at a time.
- tmr_done is ignored in IDLE, LOAD and DONE.
- req changes from the owner's psc_in or reload_in slices after the grant have no effect. The configuration is latched once, at the IDLE→LOAD edge.
- A requester that keeps req high after done re-enters arbitration at rr_ptr priority. It therefore yields to any other pending requester.

## Timing
- Edge E0: IDLE samples req. After E0, state=LOAD, gnt, busy and tmr_load are high, and tmr_psc/tmr_reload are valid.
- Edge E1: after E1, state=RUN, tmr_load=0 and tmr_en=1. The timer sees the load strobe exactly one cycle before its enable.
- Edge Ek, with tmr_done=1 sampled in RUN: after Ek, done[cur_id]=1 and tmr_en=0.
- Edge Ek+1: done=0, gnt=0, busy=0.
- Edge Ek+2: earliest edge at which IDLE can register the next grant.
- Request-to-grant latency: 1 edge.
- Completion-to-done latency: 1 edge.
- Minimum idle gap between consecutive grants: 1 cycle (the IDLE state).
- Zero-reload request: gnt is high for 2 cycles (LOAD, DONE), the done pulse lands 2 edges after the request is sampled, and tmr_en stays 0 throughout.
- Reset asserted in any state: outputs are at their reset values after that edge. No done pulse is issued, and rr_ptr returns to 0.

## Test plan
- **Single request:** N_REQ=4; req=0b0010, psc_in[1]=3, reload_in[1]=5; bench timer model pulses tmr_done 24 cycles after tmr_en rises. Required:
  - gnt=0b0010 one edge after req
  - tmr_load high for 1 cycle with tmr_psc=3 and tmr_reload=5
  - tmr_en high for 24 cycles
  - done=0b0010 for one cycle, then gnt=0 and busy=0
- **Round-robin fairness:** req=0b1011 held high continuously; each tmr_done arrives 3 cycles after tmr_en. Required grant order: 0, 1, 3, 0, 1. Each done pulse lands on the matching bit.
- **Abort:** owner 2 drops req 2 cycles into RUN. Required: next edge tmr_en=0, gnt=0, state IDLE, no done pulse, rr_ptr=3 (a pending req[3] is granted next over req[0]).
- **Abort/done collision:** tmr_done=1 and req[owner]=0 on the same edge. Required: done[owner] pulses once.
- **Zero reload:** reload_in[0]=0. Required: gnt[0] high for 2 cycles, tmr_en never high, done[0] pulses 2 edges after the req edge.
- **Reset mid-run:** reset=0 for one edge during RUN with tmr_done=1 on that same edge. Required:
  - all outputs zero, done never asserted
  - with req=0b0101 held, the next grant goes to requester 0
